// File: rtl/i8088_bus_pkg.sv
// Shared types and constants for slaves on the 8088 min-mode peripheral bus.
// Strobes are active low; IOM high selects the I/O space.
package i8088_bus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  localparam logic STROBE_ACTIVE = 1'b0;

  localparam logic IOM_MEM = 1'b0;
  localparam logic IOM_IO  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } bus_state_t;

endpackage

// File: rtl/i8088_mem_peripheral_if.sv
// Demultiplexed 8088 control/address bundle seen by a peripheral.
// The data bus is a separate tristate port on each slave.
interface i8088_mem_peripheral_if;
  import i8088_bus_pkg::*;

  logic              ale;
  logic              iom;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic              sel;

  modport master (output ale, iom, rd, wr, address, input sel);
  modport slave  (input ale, iom, rd, wr, address, output sel);

endinterface

// File: rtl/i8088_addr_decode.sv
// Latches the byte offset on ALE and decides whether this cycle targets our window.
// sel is held for the whole bus cycle and dropped by clr when the owner finishes.
module i8088_addr_decode
  import i8088_bus_pkg::*;
#(
  parameter logic              IOM_SEL   = IOM_MEM,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ale,
  input  logic                 iom,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 clr,
  output logic                 hit,
  output logic [ADDR_BITS-1:0] off_q,
  output logic                 sel
);

  logic [ADDR_W-1:ADDR_BITS] match;

  genvar gi;
  for (gi = ADDR_BITS; gi < ADDR_W; gi++) begin : g_match
    assign match[gi] = (address[gi] == BASE_ADDR[gi]);
  end

  assign hit = (iom == IOM_SEL) && (&match);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q <= '0;
      sel   <= 1'b0;
    end else if (ale) begin
      off_q <= address[ADDR_BITS-1:0];
      sel   <= hit;
    end else if (clr) begin
      sel   <= 1'b0;
    end
  end

endmodule

// File: rtl/i8088_mem_peripheral.sv
// Byte-wide memory/I-O slave on the 8088 bus: T-state tracking FSM, storage, data tristate.
// ALE always restarts the cycle, so an interrupted read or write never completes.
module i8088_mem_peripheral
  import i8088_bus_pkg::*;
#(
  parameter logic              IOM_SEL   = IOM_MEM,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 20'h00000,
  parameter int                ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  i8088_mem_peripheral_if.slave  bus,
  inout  wire  [DATA_W-1:0]      data
);

  bus_state_t             state_reg;
  bus_state_t             state_next;
  logic                   hit;
  logic [ADDR_BITS-1:0]   off_q;
  logic                   rd_on;
  logic                   wr_on;
  logic                   rd_start;
  logic                   rd_end;
  logic                   wr_sample;
  logic                   commit;
  logic                   sel_clr;
  logic                   out_en;
  logic [DATA_W-1:0]      dout_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      mem [0:(1<<ADDR_BITS)-1];

  assign rd_on = (bus.rd == STROBE_ACTIVE);
  assign wr_on = (bus.wr == STROBE_ACTIVE);

  i8088_addr_decode #(
    .IOM_SEL   (IOM_SEL),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_BITS (ADDR_BITS)
  ) u_decode (
    .clk     (clk),
    .rst     (rst),
    .ale     (bus.ale),
    .iom     (bus.iom),
    .address (bus.address),
    .clr     (sel_clr),
    .hit     (hit),
    .off_q   (off_q),
    .sel     (bus.sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.ale) begin
      state_next = hit ? ADDR : IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = IDLE;
        ADDR: begin
          if (rd_on && wr_on) begin
            state_next = IDLE;
          end else if (rd_on) begin
            state_next = READ;
          end else if (wr_on) begin
            state_next = WRITE;
          end
        end
        READ:    if (!rd_on) state_next = IDLE;
        WRITE:   if (!wr_on) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Strobe actions are suppressed on ALE edges: a new address phase wins.
  always_comb begin
    rd_start  = 1'b0;
    rd_end    = 1'b0;
    wr_sample = 1'b0;
    commit    = 1'b0;
    sel_clr   = 1'b0;
    if (!bus.ale) begin
      case (state_reg)
        ADDR: begin
          rd_start  = rd_on && !wr_on;
          wr_sample = wr_on && !rd_on;
          sel_clr   = rd_on && wr_on;
        end
        READ: begin
          rd_end  = !rd_on;
          sel_clr = !rd_on;
        end
        WRITE: begin
          wr_sample = wr_on;
          commit    = !wr_on;
          sel_clr   = !wr_on;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en  <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (bus.ale || rd_end) begin
        out_en <= 1'b0;
      end else if (rd_start) begin
        out_en <= 1'b1;
      end
      if (wr_sample) begin
        wdata_q <= data;
      end
    end
  end

  // Storage and its registered read port carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[off_q] <= wdata_q;
    end
    if (rd_start) begin
      dout_q <= mem[off_q];
    end
  end

  assign data = out_en ? dout_q : 'z;

endmodule

// File: tb/tb_i8088_mem_peripheral.sv
// Bench for i8088_mem_peripheral: directed vector table, hand-written corner sequences,
// then random bus cycles checked against an address-keyed transaction model.
module tb_i8088_mem_peripheral;
  import i8088_bus_pkg::*;

  localparam logic [19:0] BASE = 20'h0F000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tb_en = 1'b0;
  logic [7:0] tb_val = 8'h00;
  wire  [7:0] data;

  always #5 clk = ~clk;

  i8088_mem_peripheral_if bus();

  assign data = tb_en ? tb_val : 8'hzz;

  i8088_mem_peripheral #(
    .IOM_SEL   (1'b0),
    .BASE_ADDR (BASE),
    .ADDR_BITS (10)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  int total  = 0;
  int passed = 0;

  // Reference: bytes keyed by full bus address, only for cycles that should hit.
  logic [7:0] ref_mem [int];

  typedef struct {
    logic [19:0] a;
    logic        io;
    bit          wr;
    logic [7:0]  wd;
    int          pre;
    int          nstb;
    bit          exp_sel;
    bit          chk;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [16];

  function automatic bit model_hit(input logic [19:0] a, input logic io);
    return (io == 1'b0) && (int'(a) >= 'h0F000) && (int'(a) < 'h0F400);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input string name, input logic [19:0] a, input logic io,
                           input bit is_wr, input logic [7:0] wd, input int pre,
                           input int nstb, input bit exp_sel, input bit chk,
                           input logic [7:0] exp_rd);
    $display("txn %-16s a=%05h iom=%0d %s wd=%02h pre=%0d stb=%0d hit=%0d",
             name, a, io, is_wr ? "WR" : "RD", wd, pre, nstb, exp_sel);
    bus.ale = 1'b1; bus.iom = io; bus.address = a;
    tick();
    bus.ale = 1'b0; bus.iom = 1'($urandom); bus.address = 20'($urandom);
    check({name, "/sel_t1"}, 32'(bus.sel), 32'(exp_sel));
    for (int i = 0; i < pre; i++) begin
      tick();
      check({name, "/wait_drive"}, 32'(dut.out_en), 32'd0);
    end
    for (int i = 0; i < nstb; i++) begin
      if (is_wr) begin
        tb_en = 1'b1;
        tb_val = (i == nstb - 1) ? wd : 8'($urandom);
        bus.wr = 1'b0;
      end else begin
        bus.rd = 1'b0;
      end
      tick();
      check({name, "/sel_stb"}, 32'(bus.sel), 32'(exp_sel));
      check({name, "/drive"}, 32'(dut.out_en), 32'(!is_wr && exp_sel));
      if (chk) check({name, "/rdata"}, 32'(data), 32'(exp_rd));
    end
    bus.rd = 1'b1; bus.wr = 1'b1; tb_en = 1'b0;
    tick();
    check({name, "/release"}, 32'(dut.out_en), 32'd0);
    check({name, "/sel_end"}, 32'(bus.sel), 32'd0);
  endtask

  task automatic model_cycle(input string name, input logic [19:0] a, input logic io,
                             input bit is_wr, input logic [7:0] wd, input int pre,
                             input int nstb);
    bit         h;
    bit         known;
    logic [7:0] e;
    h = model_hit(a, io);
    known = !is_wr && h && ref_mem.exists(int'(a));
    e = known ? ref_mem[int'(a)] : 8'h00;
    run_cycle(name, a, io, is_wr, wd, pre, nstb, h, known, e);
    if (is_wr && h) ref_mem[int'(a)] = wd;
  endtask

  initial begin
    bus.ale = 1'b0; bus.iom = 1'b0; bus.rd = 1'b1; bus.wr = 1'b1; bus.address = '0;

    //          addr       io    wr    wd     pre nstb sel   chk   exp_rd
    vecs[0]  = '{20'h0F123, 1'b0, 1'b1, 8'hA5, 0, 2, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{20'h0F010, 1'b0, 1'b1, 8'h00, 0, 1, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{20'h0F050, 1'b0, 1'b1, 8'h11, 0, 1, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{20'h0F123, 1'b0, 1'b0, 8'h00, 0, 1, 1'b1, 1'b1, 8'hA5};
    vecs[4]  = '{20'h0F400, 1'b0, 1'b0, 8'h00, 0, 2, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{20'h1F123, 1'b0, 1'b0, 8'h00, 0, 2, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{20'h0F123, 1'b0, 1'b0, 8'h00, 0, 1, 1'b1, 1'b1, 8'hA5};
    vecs[7]  = '{20'h0F010, 1'b1, 1'b1, 8'h3C, 0, 2, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{20'h0F010, 1'b0, 1'b0, 8'h00, 0, 1, 1'b1, 1'b1, 8'h00};
    vecs[9]  = '{20'h0F123, 1'b0, 1'b0, 8'h00, 3, 5, 1'b1, 1'b1, 8'hA5};
    vecs[10] = '{20'h0F123, 1'b1, 1'b0, 8'h00, 0, 1, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{20'h0F3FF, 1'b0, 1'b1, 8'h5A, 1, 3, 1'b1, 1'b0, 8'h00};
    vecs[12] = '{20'h0F3FF, 1'b0, 1'b0, 8'h00, 0, 2, 1'b1, 1'b1, 8'h5A};
    vecs[13] = '{20'h0F000, 1'b0, 1'b1, 8'hC3, 0, 1, 1'b1, 1'b0, 8'h00};
    vecs[14] = '{20'h0F000, 1'b0, 1'b0, 8'h00, 0, 1, 1'b1, 1'b1, 8'hC3};
    vecs[15] = '{20'h0EFFF, 1'b0, 1'b0, 8'h00, 0, 2, 1'b0, 1'b0, 8'h00};

    tick();
    tick();
    check("reset/drive", 32'(dut.out_en), 32'd0);
    check("reset/sel", 32'(bus.sel), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      run_cycle($sformatf("vec%0d", i), vecs[i].a, vecs[i].io, vecs[i].wr, vecs[i].wd,
                vecs[i].pre, vecs[i].nstb, vecs[i].exp_sel, vecs[i].chk, vecs[i].exp_rd);
      if (vecs[i].wr && model_hit(vecs[i].a, vecs[i].io)) ref_mem[int'(vecs[i].a)] = vecs[i].wd;
    end

    // Both strobes low in ADDR, then strobes seen while idle.
    $display("txn proto-error     a=0f123 RD+WR low together, then idle strobes");
    bus.ale = 1'b1; bus.iom = 1'b0; bus.address = 20'h0F123;
    tick();
    bus.ale = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    tick();
    check("proto/drive", 32'(dut.out_en), 32'd0);
    check("proto/sel", 32'(bus.sel), 32'd0);
    bus.rd = 1'b1; tb_en = 1'b1; tb_val = 8'hEE;
    tick();
    check("idle_wr/drive", 32'(dut.out_en), 32'd0);
    bus.wr = 1'b1; tb_en = 1'b0; bus.rd = 1'b0;
    tick();
    check("idle_rd/drive", 32'(dut.out_en), 32'd0);
    bus.rd = 1'b1;
    tick();
    model_cycle("proto/readback", 20'h0F123, 1'b0, 1'b0, 8'h00, 0, 1);

    // Write of 77 abandoned by a fresh ALE while WR is still low.
    $display("txn abort           a=0f050 WR 77 interrupted by ALE");
    bus.ale = 1'b1; bus.iom = 1'b0; bus.address = 20'h0F050;
    tick();
    bus.ale = 1'b0; tb_en = 1'b1; tb_val = 8'h77; bus.wr = 1'b0;
    tick();
    tick();
    bus.ale = 1'b1; bus.address = 20'h0F200;
    tick();
    check("abort/sel_new", 32'(bus.sel), 32'd1);
    bus.ale = 1'b0; bus.wr = 1'b1; tb_en = 1'b0;
    tick();
    check("abort/drive", 32'(dut.out_en), 32'd0);
    model_cycle("abort/readback", 20'h0F050, 1'b0, 1'b0, 8'h00, 0, 1);

    // Reset lands between clock edges while the read data is on the bus.
    $display("txn async-reset     a=0f123 RESET during driven read");
    bus.ale = 1'b1; bus.iom = 1'b0; bus.address = 20'h0F123;
    tick();
    bus.ale = 1'b0; bus.rd = 1'b0;
    tick();
    check("rst/pre_drive", 32'(dut.out_en), 32'd1);
    check("rst/pre_data", 32'(data), 32'hA5);
    #2 rst = 1'b1;
    #1;
    check("rst/drive", 32'(dut.out_en), 32'd0);
    check("rst/sel", 32'(bus.sel), 32'd0);
    bus.rd = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    model_cycle("rst/readback", 20'h0F123, 1'b0, 1'b0, 8'h00, 0, 1);

    for (int n = 0; n < 200; n++) begin
      logic [19:0] a;
      logic        io;
      bit          w;
      a  = ($urandom_range(3) != 0) ? (BASE | 20'($urandom_range(1023))) : 20'($urandom);
      io = ($urandom_range(3) == 0);
      w  = 1'($urandom_range(1));
      model_cycle($sformatf("rnd%0d", n), a, io, w, 8'($urandom),
                  int'($urandom_range(2)), int'($urandom_range(4, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
